v_issue_ctrl: RTL

- Issue-control stage directly upstream of the vector register hazard checker.
- Buffers decoded vector instructions in a small FIFO and queries the hazard checker for the source registers of the head instruction.
- Hands the instruction downstream once the registers are clear, and marks its destination register pending in the checker at the moment of issue.

---
 rtl/v_issue_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/v_issue_ctrl.sv
// rtl/v_issue_ctrl.sv - vector issue control: instruction FIFO, hazard query FSM, issue handshake
module v_issue_ctrl #(
    parameter int ADDR_WIDTH  = 5,
    parameter int INSTR_WIDTH = 32,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INSTR_WIDTH-1:0] in_instr,
    input  logic [ADDR_WIDTH-1:0]  in_vs1,
    input  logic [ADDR_WIDTH-1:0]  in_vs2,
    input  logic                   in_use_vs1,
    input  logic                   in_use_vs2,
    input  logic [ADDR_WIDTH-1:0]  in_vd,
    input  logic                   in_wr_vd,
    output logic                   check_hazard0,
    output logic                   check_hazard1,
    output logic [ADDR_WIDTH-1:0]  check_wr_addr0,
    output logic [ADDR_WIDTH-1:0]  check_wr_addr1,
    input  logic                   no_hazard,
    output logic                   update_expected_wb_addr,
    output logic [ADDR_WIDTH-1:0]  expected_wb_addr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INSTR_WIDTH-1:0] out_instr,
    output logic [ADDR_WIDTH-1:0]  out_vd,
    output logic [15:0]            stall_cycles
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef struct packed {
        logic [INSTR_WIDTH-1:0] instr;
        logic [ADDR_WIDTH-1:0]  vs1;
        logic [ADDR_WIDTH-1:0]  vs2;
        logic [ADDR_WIDTH-1:0]  vd;
        logic                   use_vs1;
        logic                   use_vs2;
        logic                   wr_vd;
    } entry_t;

    typedef enum logic [1:0] {IDLE, CHECK, EVAL, ISSUE} state_t;

    entry_t           mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    state_t           state_q, state_d;
    logic [15:0]      stall_q, stall_d;
    entry_t           head, in_entry;
    logic             push, pop, fifo_empty;

    assign in_ready   = (count_q != FULL_CNT);
    assign fifo_empty = (count_q == '0);
    assign push       = in_valid & in_ready;
    assign pop        = out_valid & out_ready;
    assign head       = mem_q[rd_ptr_q];
    assign in_entry   = {in_instr, in_vs1, in_vs2, in_vd, in_use_vs1, in_use_vs2, in_wr_vd};

    assign check_wr_addr0 = head.vs1;
    assign check_wr_addr1 = head.vs2;
    assign out_instr      = head.instr;
    assign out_vd         = head.vd;
    assign stall_cycles   = stall_q;

    // Storage is cleared on reset so the combinational head-driven outputs read 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= IDLE;
            stall_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= in_entry;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
            state_q <= state_d;
            stall_q <= stall_d;
        end
    end

    always_comb begin
        state_d                 = state_q;
        stall_d                 = stall_q;
        check_hazard0           = 1'b0;
        check_hazard1           = 1'b0;
        out_valid               = 1'b0;
        update_expected_wb_addr = 1'b0;
        expected_wb_addr        = '0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) state_d = CHECK;
            end
            CHECK: begin
                check_hazard0 = head.use_vs1;
                check_hazard1 = head.use_vs2;
                state_d       = (head.use_vs1 | head.use_vs2) ? EVAL : ISSUE;
            end
            EVAL: begin
                if (no_hazard) begin
                    state_d = ISSUE;
                end else begin
                    state_d = CHECK;
                    if (stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
                end
            end
            ISSUE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (head.wr_vd) begin
                        update_expected_wb_addr = 1'b1;
                        expected_wb_addr        = head.vd;
                    end
                    // Entries left after this pop, including one arriving this cycle.
                    state_d = ((count_q != CNT_W'(1)) || push) ? CHECK : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
